// File: rtl/csa_accumulator.sv
// rtl/csa_accumulator.sv - carry-save multi-operand accumulator with grouped result handshake
// Sums NOPS operands per beat into redundant S/C state; one carry-propagate add per group.
module csa_accumulator #(
   parameter int WIDTH     = 4,
   parameter int NOPS      = 4,
   parameter int ACC_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [NOPS*WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_WIDTH-1:0]  out_sum,
   output logic [15:0]           out_beats
);

   typedef enum logic [1:0] {ACCUM, RESOLVE, HOLD} state_t;

   state_t               state;
   state_t               state_nxt;
   logic [ACC_WIDTH-1:0] s_reg;
   logic [ACC_WIDTH-1:0] c_reg;
   logic [ACC_WIDTH-1:0] s_nxt;
   logic [ACC_WIDTH-1:0] c_nxt;
   logic [ACC_WIDTH-1:0] op;
   logic [ACC_WIDTH-1:0] maj;
   logic [15:0]          beat_cnt;
   logic                 accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ACCUM;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ACCUM: begin
            in_ready = !clr;
            if (in_valid && !clr && in_last) begin
               state_nxt = RESOLVE;
            end
         end
         RESOLVE: state_nxt = HOLD;
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = ACCUM;
            end
         end
         default: state_nxt = ACCUM;
      endcase
   end

   assign accept = in_valid && in_ready;

   // Chain of 3:2 compressors: each operand folds into (S, C) with no carry ripple.
   always_comb begin
      s_nxt = s_reg;
      c_nxt = c_reg;
      op    = '0;
      maj   = '0;
      for (int i = 0; i < NOPS; i++) begin
         op    = ACC_WIDTH'(in_data[i*WIDTH +: WIDTH]);
         maj   = (s_nxt & c_nxt) | (s_nxt & op) | (c_nxt & op);
         s_nxt = s_nxt ^ c_nxt ^ op;
         c_nxt = maj << 1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_reg     <= '0;
         c_reg     <= '0;
         beat_cnt  <= '0;
         out_sum   <= '0;
         out_beats <= '0;
      end else begin
         case (state)
            ACCUM: begin
               if (clr) begin
                  s_reg    <= '0;
                  c_reg    <= '0;
                  beat_cnt <= '0;
               end else if (accept) begin
                  s_reg <= s_nxt;
                  c_reg <= c_nxt;
                  if (beat_cnt != 16'hFFFF) begin
                     beat_cnt <= beat_cnt + 16'd1;
                  end
               end
            end
            RESOLVE: begin
               out_sum   <= s_reg + c_reg;
               out_beats <= beat_cnt;
            end
            HOLD: begin
               if (out_ready) begin
                  s_reg    <= '0;
                  c_reg    <= '0;
                  beat_cnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_csa_accumulator.sv
// tb/tb_csa_accumulator.sv - self-checking bench for csa_accumulator
// Reference tracks the group total as a plain integer sum and a phase number.
module tb_csa_accumulator;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  out_sum;
   logic [15:0] out_beats;

   int vectors = 0;
   int miscompares = 0;

   int ph = 0;
   int acc = 0;
   int cnt = 0;
   int m_sum_out = 0;
   int m_beats_out = 0;

   csa_accumulator #(.WIDTH(4), .NOPS(4), .ACC_WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_beats (out_beats)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] pk(input int a, input int b, input int c, input int e);
      logic [3:0] na, nb, nc, ne;
      na = a[3:0];
      nb = b[3:0];
      nc = c[3:0];
      ne = e[3:0];
      return {ne, nc, nb, na};
   endfunction

   function automatic int opsum(input logic [15:0] d);
      return int'(d[3:0]) + int'(d[7:4]) + int'(d[11:8]) + int'(d[15:12]);
   endfunction

   task automatic step(input logic r, input logic c, input logic v, input logic [15:0] d,
                       input logic l, input logic o);
      rst = r; clr = c; in_valid = v; in_data = d; in_last = l; out_ready = o;
      @(negedge clk);
      if (!r) begin
         check("in_ready", 32'(in_ready), 32'(ph == 0 && !c));
         check("out_valid", 32'(out_valid), 32'(ph == 2));
         check("out_sum", 32'(out_sum), 32'(m_sum_out));
         check("out_beats", 32'(out_beats), 32'(m_beats_out));
      end
      @(posedge clk);
      #1;
      if (r) begin
         ph = 0; acc = 0; cnt = 0; m_sum_out = 0; m_beats_out = 0;
      end else begin
         case (ph)
            0: begin
               if (c) begin
                  acc = 0; cnt = 0;
               end else if (v) begin
                  acc = (acc + opsum(d)) % 256;
                  if (cnt < 65535) cnt++;
                  if (l) ph = 1;
               end
            end
            1: begin
               m_sum_out = acc; m_beats_out = cnt; ph = 2;
            end
            default: begin
               if (o) begin
                  acc = 0; cnt = 0; ph = 0;
               end
            end
         endcase
      end
      rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
   endtask

   task automatic expect_hold(input string tag, input int s, input int b);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_sum"}, 32'(out_sum), 32'(s));
      check({tag, "_beats"}, 32'(out_beats), 32'(b));
   endtask

   task automatic release_hold(input string tag);
      step(0, 0, 0, '0, 0, 1);
      check({tag, "_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_valid", 32'(out_valid), 32'd0);
      check("reset_sum", 32'(out_sum), 32'd0);
      check("reset_beats", 32'(out_beats), 32'd0);
      check("reset_ready", 32'(in_ready), 32'd1);

      // single beat; out_valid must not appear one cycle after the last handshake
      step(0, 0, 1, pk(3, 5, 7, 9), 1, 0);
      check("single_lat1", 32'(out_valid), 32'd0);
      step(0, 0, 0, '0, 0, 0);
      expect_hold("single", 24, 1);
      release_hold("single");

      repeat (2) step(0, 0, 1, pk(15, 15, 15, 15), 0, 0);
      step(0, 0, 1, pk(15, 15, 15, 15), 1, 0);
      step(0, 0, 0, '0, 0, 0);
      expect_hold("multi", 180, 3);
      release_hold("multi");

      repeat (4) step(0, 0, 1, pk(15, 15, 15, 15), 0, 0);
      step(0, 0, 1, pk(15, 15, 15, 15), 1, 0);
      step(0, 0, 0, '0, 0, 0);
      expect_hold("wrap", 44, 5);
      release_hold("wrap");

      step(0, 0, 1, pk(1, 2, 3, 4), 1, 0);
      step(0, 0, 0, '0, 0, 0);
      repeat (5) step(0, 1, 1, pk(15, 15, 15, 15), 1, 0);
      expect_hold("bp", 10, 1);
      release_hold("bp");
      step(0, 0, 1, pk(1, 1, 1, 1), 1, 0);
      step(0, 0, 0, '0, 0, 0);
      expect_hold("bp_next", 4, 1);
      release_hold("bp_next");

      repeat (2) step(0, 0, 1, pk(1, 1, 1, 1), 0, 0);
      step(1, 0, 0, '0, 0, 0);
      step(0, 0, 1, pk(1, 1, 1, 1), 1, 0);
      step(0, 0, 0, '0, 0, 0);
      expect_hold("rst_mid", 4, 1);
      release_hold("rst_mid");

      step(0, 1, 1, pk(9, 9, 9, 9), 0, 0);
      step(0, 0, 1, pk(2, 2, 2, 2), 1, 0);
      step(0, 0, 0, '0, 0, 0);
      expect_hold("clr_hit", 8, 1);
      release_hold("clr_hit");

      // reset while a result is held must discard it
      step(0, 0, 1, pk(6, 6, 6, 6), 1, 0);
      step(0, 0, 0, '0, 0, 0);
      step(1, 0, 0, '0, 0, 0);
      check("rst_hold_valid", 32'(out_valid), 32'd0);
      check("rst_hold_sum", 32'(out_sum), 32'd0);

      for (int n = 0; n < 800; n++) begin
         step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 8,
              $urandom_range(0, 99) < 75, 16'($urandom),
              $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 50);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
